// File: rtl/pio_out_bank_if.sv
// Avalon-MM slave bus and output pins of one PIO output bank.
// Fixed-latency slave with no waitrequest: write = chipselect & ~write_n takes effect at the sampling edge, read = chipselect & read & write_n returns readdata one cycle later.
`timescale 1ns/1ps
interface pio_out_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = $clog2(CHANNELS) + 2
);
    logic [ADDR_W-1:0]         address;
    logic                      chipselect;
    logic                      read;
    logic                      write_n;
    logic [31:0]               writedata;
    logic [31:0]               readdata;
    logic [CHANNELS*WIDTH-1:0] out_port;
    logic [CHANNELS-1:0]       pulse_active;

    modport master (
        output address, chipselect, read, write_n, writedata,
        input  readdata, out_port, pulse_active
    );

    modport slave (
        input  address, chipselect, read, write_n, writedata,
        output readdata, out_port, pulse_active
    );
endinterface

// File: rtl/pio_out_bank.sv
// Bank of CHANNELS output registers with atomic DATA/SET/CLEAR/PULSE writes and 1-cycle registered readback.
`timescale 1ns/1ps
module pio_out_bank #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 16,
    parameter int ADDR_W       = $clog2(CHANNELS) + 2
) (
    input logic           clk,
    input logic           reset,
    pio_out_bank_if.slave bus
);
    localparam int               CNT_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_SET   = 2'd1;
    localparam logic [1:0] OFF_CLEAR = 2'd2;
    localparam logic [1:0] OFF_PULSE = 2'd3;

    logic                         w_wr;
    logic                         w_rd;
    logic [ADDR_W-1:0]            w_ch_idx;
    logic [1:0]                   w_off;
    logic [WIDTH-1:0]             w_wd;
    logic [CHANNELS-1:0][31:0]    w_rd_word;
    logic [31:0]                  w_rd_mux;
    logic [31:0]                  r_readdata;
    logic                         w_unused_wdata;

    // A cycle with both strobes is a write only.
    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_rd     = bus.chipselect & bus.read & bus.write_n;
    assign w_ch_idx = bus.address >> 2;
    assign w_off    = bus.address[1:0];
    assign w_wd     = bus.writedata[WIDTH-1:0];

    assign w_unused_wdata = ^bus.writedata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] r_out;
        logic [WIDTH-1:0] r_pmask;
        logic [CNT_W-1:0] r_cnt;
        logic             r_active;
        logic [WIDTH-1:0] w_out_nxt;
        logic [WIDTH-1:0] w_pmask_nxt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_sel;
        logic             w_expire;

        // Unmapped channel indices never match any c, so they are ignored and read 0.
        assign w_sel = (w_ch_idx == ADDR_W'(c));

        // Expiry is applied first; a same-cycle write then acts on the post-expiry values.
        always_comb begin
            w_expire    = (r_cnt == CNT_ONE);
            w_out_nxt   = w_expire ? (r_out & ~r_pmask) : r_out;
            w_pmask_nxt = w_expire ? '0 : r_pmask;
            w_cnt_nxt   = (r_cnt > CNT_ONE) ? (r_cnt - CNT_ONE) : '0;
            if (w_wr && w_sel) begin
                case (w_off)
                    OFF_DATA: begin
                        w_out_nxt   = w_wd;
                        w_pmask_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                    OFF_SET: begin
                        w_out_nxt = w_out_nxt | w_wd;
                    end
                    OFF_CLEAR: begin
                        w_out_nxt   = w_out_nxt & ~w_wd;
                        w_pmask_nxt = w_pmask_nxt & ~w_wd;
                    end
                    default: begin
                        w_out_nxt   = w_out_nxt | w_wd;
                        w_pmask_nxt = w_pmask_nxt | w_wd;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_out    <= '0;
                r_pmask  <= '0;
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_out    <= w_out_nxt;
                r_pmask  <= w_pmask_nxt;
                r_cnt    <= w_cnt_nxt;
                r_active <= (w_cnt_nxt != '0);
            end
        end

        assign w_rd_word[c] = !w_sel              ? 32'd0 :
                              (w_off == OFF_PULSE) ? 32'(r_pmask) : 32'(r_out);

        assign bus.out_port[c*WIDTH +: WIDTH] = r_out;
        assign bus.pulse_active[c]            = r_active;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_rd_mux = w_rd_mux | w_rd_word[c];
        end
    end

    // Read data is captured from pre-update state and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_pio_out_bank.sv
// Directed bench: default bank (4x8, 16-cycle pulse) plus a 3x32 bank with 1-cycle pulse.
`timescale 1ns/1ps
module tb_pio_out_bank;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pio_out_bank_if #(.CHANNELS(4), .WIDTH(8))  a_if ();
    pio_out_bank_if #(.CHANNELS(3), .WIDTH(32)) b_if ();

    pio_out_bank #(.CHANNELS(4), .WIDTH(8), .PULSE_CYCLES(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    pio_out_bank #(.CHANNELS(3), .WIDTH(32), .PULSE_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input int ch, input int off, input logic [31:0] data);
        a_if.address    = 4'(ch * 4 + off);
        a_if.writedata  = data;
        a_if.chipselect = 1'b1;
        a_if.write_n    = 1'b0;
        tick(1);
        a_if.chipselect = 1'b0;
        a_if.write_n    = 1'b1;
    endtask

    task automatic rd_a(input int ch, input int off);
        a_if.address    = 4'(ch * 4 + off);
        a_if.chipselect = 1'b1;
        a_if.read       = 1'b1;
        tick(1);
        a_if.chipselect = 1'b0;
        a_if.read       = 1'b0;
    endtask

    task automatic wr_b(input int ch, input int off, input logic [31:0] data);
        b_if.address    = 4'(ch * 4 + off);
        b_if.writedata  = data;
        b_if.chipselect = 1'b1;
        b_if.write_n    = 1'b0;
        tick(1);
        b_if.chipselect = 1'b0;
        b_if.write_n    = 1'b1;
    endtask

    task automatic rd_b(input int ch, input int off);
        b_if.address    = 4'(ch * 4 + off);
        b_if.chipselect = 1'b1;
        b_if.read       = 1'b1;
        tick(1);
        b_if.chipselect = 1'b0;
        b_if.read       = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.address = '0; a_if.chipselect = 1'b0; a_if.read = 1'b0;
        a_if.write_n = 1'b1; a_if.writedata = '0;
        b_if.address = '0; b_if.chipselect = 1'b0; b_if.read = 1'b0;
        b_if.write_n = 1'b1; b_if.writedata = '0;

        // Reset for two cycles
        reset = 1'b1;
        tick(2);
        chk("rst_out_a", a_if.out_port, 0);
        chk("rst_rd_a", a_if.readdata, 0);
        chk("rst_pa_a", a_if.pulse_active, 0);
        chk("rst_out_b", b_if.out_port, 0);
        chk("rst_rd_b", b_if.readdata, 0);
        chk("rst_pa_b", b_if.pulse_active, 0);
        reset = 1'b0;

        // Basic write / read
        wr_a(2, 0, 32'hA5);
        chk("data_ch2", a_if.out_port, 32'h00A5_0000);
        rd_a(2, 0);
        chk("rd_ch2", a_if.readdata, 32'h0000_00A5);

        // Set / clear
        wr_a(0, 0, 32'h0F);
        wr_a(0, 1, 32'h30);
        chk("set_ch0", a_if.out_port, 32'h00A5_003F);
        wr_a(0, 2, 32'h03);
        chk("clr_ch0", a_if.out_port, 32'h00A5_003C);
        rd_a(0, 1);
        chk("rd_set_off", a_if.readdata, 32'h3C);
        rd_a(0, 3);
        chk("rd_pmask_idle", a_if.readdata, 32'h0);

        // Pulse timing: 0x80 high for exactly 16 cycles
        wr_a(1, 0, 32'h01);
        wr_a(1, 3, 32'h80);
        chk("pulse_start", a_if.out_port, 32'h00A5_813C);
        chk("pulse_pa_start", a_if.pulse_active, 4'b0010);
        for (int i = 1; i < 16; i++) begin
            tick(1);
            chk("pulse_hold", a_if.out_port, 32'h00A5_813C);
            chk("pulse_pa_hold", a_if.pulse_active, 4'b0010);
        end
        tick(1);
        chk("pulse_end", a_if.out_port, 32'h00A5_013C);
        chk("pulse_pa_end", a_if.pulse_active, 4'b0000);

        // Extend, clear mid-pulse, cancel with DATA
        wr_a(1, 3, 32'h80);
        tick(4);
        wr_a(1, 3, 32'h02);
        chk("extend_out", a_if.out_port, 32'h00A5_833C);
        rd_a(1, 3);
        chk("extend_pmask", a_if.readdata, 32'h82);
        chk("extend_pa", a_if.pulse_active, 4'b0010);
        wr_a(1, 2, 32'h80);
        chk("midclr_out", a_if.out_port, 32'h00A5_033C);
        rd_a(1, 3);
        chk("midclr_pmask", a_if.readdata, 32'h02);
        wr_a(1, 0, 32'h55);
        chk("cancel_pa", a_if.pulse_active, 4'b0000);
        chk("cancel_out", a_if.out_port, 32'h00A5_553C);
        tick(20);
        chk("cancel_hold", a_if.out_port, 32'h00A5_553C);
        rd_a(1, 3);
        chk("cancel_pmask", a_if.readdata, 32'h0);

        // SET on the expiry edge
        wr_a(3, 0, 32'h10);
        wr_a(3, 3, 32'h01);
        chk("col_start", a_if.out_port, 32'h11A5_553C);
        tick(15);
        chk("col_pre", a_if.out_port, 32'h11A5_553C);
        chk("col_pre_pa", a_if.pulse_active, 4'b1000);
        wr_a(3, 1, 32'h04);
        chk("col_set", a_if.out_port, 32'h14A5_553C);
        chk("col_set_pa", a_if.pulse_active, 4'b0000);

        // PULSE on the expiry edge starts a fresh full-length pulse
        wr_a(3, 3, 32'h20);
        chk("col2_start", a_if.out_port, 32'h34A5_553C);
        tick(15);
        wr_a(3, 3, 32'h08);
        chk("col2_out", a_if.out_port, 32'h1CA5_553C);
        chk("col2_pa", a_if.pulse_active, 4'b1000);
        rd_a(3, 3);
        chk("col2_pmask", a_if.readdata, 32'h08);
        tick(14);
        chk("col2_hold", a_if.out_port, 32'h1CA5_553C);
        chk("col2_hold_pa", a_if.pulse_active, 4'b1000);
        tick(1);
        chk("col2_end", a_if.out_port, 32'h14A5_553C);
        chk("col2_end_pa", a_if.pulse_active, 4'b0000);

        // Both strobes: write happens, no read
        a_if.address = 4'h0; a_if.writedata = 32'h99;
        a_if.chipselect = 1'b1; a_if.write_n = 1'b0; a_if.read = 1'b1;
        tick(1);
        a_if.chipselect = 1'b0; a_if.write_n = 1'b1; a_if.read = 1'b0;
        chk("dual_out", a_if.out_port, 32'h14A5_5599);
        chk("dual_rd_held", a_if.readdata, 32'h08);

        // Write without chipselect is ignored
        a_if.address = 4'h0; a_if.writedata = 32'h11; a_if.write_n = 1'b0;
        tick(1);
        a_if.write_n = 1'b1;
        chk("nocs_out", a_if.out_port, 32'h14A5_5599);

        // 32-bit width, unmapped channel, 1-cycle pulse
        wr_b(0, 0, 32'hFFFF_FFFF);
        chk("w32_out", b_if.out_port, {32'h0, 32'h0, 32'hFFFF_FFFF});
        rd_b(0, 0);
        chk("w32_rd", b_if.readdata, 32'hFFFF_FFFF);
        wr_b(3, 0, 32'h1234_5678);
        chk("unmap_out", b_if.out_port, {32'h0, 32'h0, 32'hFFFF_FFFF});
        rd_b(3, 0);
        chk("unmap_rd", b_if.readdata, 32'h0);
        wr_b(1, 3, 32'h0000_F000);
        chk("p1_out", b_if.out_port, {32'h0, 32'h0000_F000, 32'hFFFF_FFFF});
        chk("p1_pa", b_if.pulse_active, 3'b010);
        tick(1);
        chk("p1_end", b_if.out_port, {32'h0, 32'h0, 32'hFFFF_FFFF});
        chk("p1_end_pa", b_if.pulse_active, 3'b000);

        // Reset mid-pulse
        wr_a(2, 3, 32'h0F);
        chk("rstp_start", a_if.out_port, 32'h14AF_5599);
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rstp_out_a", a_if.out_port, 0);
        chk("rstp_pa_a", a_if.pulse_active, 0);
        chk("rstp_rd_a", a_if.readdata, 0);
        chk("rstp_out_b", b_if.out_port, 0);
        chk("rstp_rd_b", b_if.readdata, 0);
        reset = 1'b0;
        tick(1);
        chk("rstp_after", a_if.out_port, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
